muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_if.sv | 16 +
 rtl/muldiv_unit.sv | 80 ++++++++
 tb/tb_muldiv_unit.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the core and the RV32M multiply/divide unit.
interface muldiv_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_addr;
  logic        busy;
  logic [31:0] Write_Data;
  logic [4:0]  Write_Adress;
  logic        Write_Enable;
  modport slave (input start, funct3, rs1_data, rs2_data, rd_addr,
                 output busy, Write_Data, Write_Adress, Write_Enable);
  modport master (output start, funct3, rs1_data, rs2_data, rd_addr,
                  input busy, Write_Data, Write_Adress, Write_Enable);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, fixed 33-cycle latency from accept to register-file write.
module muldiv_unit (
  input logic      clock,
  input logic      reset,
  muldiv_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0]  op_q;
  logic [4:0]  rd_q, cnt_q, wa_q;
  logic [31:0] sh_q, m_q, wd_q;
  logic [63:0] acc_q;
  logic        negr_q, nega_q;
  logic        sa, sb, na, nb, ge;
  logic [31:0] mag_a, mag_b, nr, quo, rem, res;
  logic [32:0] r33;
  logic [63:0] acc_next, prod;
  always_comb begin
    sa = bus.funct3 inside {3'b001, 3'b010, 3'b100, 3'b110};
    sb = bus.funct3 inside {3'b001, 3'b100, 3'b110};
    na = sa & bus.rs1_data[31];
    nb = sb & bus.rs2_data[31];
    mag_a = na ? -bus.rs1_data : bus.rs1_data;
    mag_b = nb ? -bus.rs2_data : bus.rs2_data;
    // MSB-first: multiply accumulates acc*2 + bit*m, divide shifts a dividend bit into the remainder
    r33 = {acc_q[63:32], sh_q[31]};
    ge = r33 >= {1'b0, m_q};
    nr = ge ? r33[31:0] - m_q : r33[31:0];
    acc_next = op_q[2] ? {nr, acc_q[30:0], ge}
                       : {acc_q[62:0], 1'b0} + (sh_q[31] ? {32'b0, m_q} : 64'b0);
    prod = negr_q ? -acc_next : acc_next;
    quo = acc_next[31:0];
    rem = acc_next[63:32];
    res = !op_q[2] ? (op_q[1:0] == 2'b00 ? prod[31:0] : prod[63:32])
        : op_q[1]  ? (nega_q ? -rem : rem)
        : (m_q == '0 ? 32'hFFFF_FFFF : negr_q ? -quo : quo);
    state_d = state_q == IDLE ? (bus.start ? CALC : IDLE)
            : state_q == CALC ? (cnt_q == 5'd31 ? DONE : CALC)
            : IDLE;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      negr_q  <= 1'b0;
      nega_q  <= 1'b0;
      wd_q    <= '0;
      wa_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.start) begin
        op_q   <= bus.funct3;
        rd_q   <= bus.rd_addr;
        cnt_q  <= '0;
        sh_q   <= mag_a;
        m_q    <= mag_b;
        acc_q  <= '0;
        negr_q <= na ^ nb;
        nega_q <= na;
      end else if (state_q == CALC) begin
        cnt_q <= cnt_q + 5'd1;
        sh_q  <= {sh_q[30:0], 1'b0};
        acc_q <= acc_next;
        if (cnt_q == 5'd31) begin
          wd_q <= res;
          wa_q <= rd_q;
        end
      end
    end
  end
  assign bus.busy         = state_q != IDLE;
  assign bus.Write_Data   = wd_q;
  assign bus.Write_Adress = wa_q;
  assign bus.Write_Enable = state_q == DONE && wa_q != '0;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed RV32M cases plus randomized ops checked against an arithmetic reference model.
module tb_muldiv_unit;
  logic clock;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  muldiv_if bus ();
  muldiv_unit dut (.clock(clock), .reset(reset), .bus(bus));
  initial clock = 1'b0;
  always #5 clock = ~clock;
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, p, q;
    logic [63:0] ua, ub, up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * $signed(ub); return p[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sa / sb;
        return q[31:0];
      end
      3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        q = sa % sb;
        return q[31:0];
      end
      default: return b == 0 ? a : a % b;
    endcase
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int repulse);
    int first = -1;
    int pulses = 0;
    logic [31:0] d = '0;
    logic [4:0] ad = '0;
    @(negedge clock);
    bus.start = 1'b1;
    bus.funct3 = op;
    bus.rs1_data = a;
    bus.rs2_data = b;
    bus.rd_addr = rd;
    @(negedge clock);
    bus.start = 1'b0;
    bus.funct3 = 3'($urandom);
    bus.rs1_data = $urandom;
    bus.rs2_data = $urandom;
    bus.rd_addr = 5'($urandom);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_accept got %b exp 1", name, bus.busy);
    end
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (repulse > 0 && n == repulse) begin
        bus.start = 1'b1;
        bus.funct3 = 3'($urandom);
        bus.rs1_data = $urandom;
        bus.rs2_data = $urandom;
        bus.rd_addr = 5'($urandom_range(1, 31));
      end
      if (repulse > 0 && n == repulse + 1) bus.start = 1'b0;
      if (bus.Write_Enable === 1'b1) begin
        pulses++;
        if (first < 0) begin
          first = n;
          d = bus.Write_Data;
          ad = bus.Write_Adress;
        end
      end
      if (n == 32 || n == 33) begin
        checks++;
        if (bus.busy !== (n == 32)) begin
          errors++;
          $display("FAIL %s busy_at_edge_%0d got %b exp %b", name, n, bus.busy, n == 32);
        end
      end
    end
    checks++;
    if (pulses !== (rd != 0 ? 1 : 0)) begin
      errors++;
      $display("FAIL %s we_pulses got %0d exp %0d", name, pulses, rd != 0 ? 1 : 0);
    end
    if (rd != 0) begin
      checks += 3;
      if (first !== 32) begin
        errors++;
        $display("FAIL %s latency got %0d exp 32", name, first);
      end
      if (d !== exp) begin
        errors++;
        $display("FAIL %s data op=%0d a=%h b=%h got %h exp %h", name, op, a, b, d, exp);
      end
      if (ad !== rd) begin
        errors++;
        $display("FAIL %s addr got %0d exp %0d", name, ad, rd);
      end
    end
  endtask
  task automatic test_reset();
    reset = 1'b0;
    bus.start = 1'b0;
    bus.funct3 = '0;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    bus.rd_addr = '0;
    #1;
    checks++;
    if ({bus.busy, bus.Write_Enable, bus.Write_Data, bus.Write_Adress} !== '0) begin
      errors++;
      $display("FAIL reset_t0 got busy=%b we=%b wd=%h wa=%h exp all 0", bus.busy, bus.Write_Enable, bus.Write_Data, bus.Write_Adress);
    end
    repeat (3) @(negedge clock);
    checks++;
    if ({bus.busy, bus.Write_Enable, bus.Write_Data, bus.Write_Adress} !== '0) begin
      errors++;
      $display("FAIL reset_held got busy=%b we=%b wd=%h wa=%h exp all 0", bus.busy, bus.Write_Enable, bus.Write_Data, bus.Write_Adress);
    end
    reset = 1'b1;
  endtask
  task automatic test_mul();
    run_op("mul_7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 0);
    run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, 0);
    run_op("mulh_m1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0, 0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd8, 32'hFFFF_FFFF, 0);
  endtask
  task automatic test_div();
    run_op("div_-7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD, 0);
    run_op("rem_-7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, 0);
    run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 5'd11, 32'd14, 0);
    run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 5'd12, 32'd2, 0);
  endtask
  task automatic test_div_special();
    run_op("div_by0", 3'd4, 32'd42, 32'd0, 5'd13, 32'hFFFF_FFFF, 0);
    run_op("rem_by0", 3'd6, 32'd42, 32'd0, 5'd14, 32'd42, 0);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 0);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0, 0);
    run_op("remu_by0", 3'd7, 32'hDEAD_BEEF, 32'd0, 5'd17, 32'hDEAD_BEEF, 0);
  endtask
  task automatic test_restart();
    run_op("repulse_ignored", 3'd0, 32'd1234, 32'd5678, 5'd18, 32'd7006652, 10);
    run_op("rd0_no_write", 3'd5, 32'd99, 32'd3, 5'd0, 32'd33, 0);
  endtask
  task automatic test_reset_abort();
    int pulses = 0;
    @(negedge clock);
    bus.start = 1'b1;
    bus.funct3 = 3'd0;
    bus.rs1_data = 32'd3;
    bus.rs2_data = 32'd4;
    bus.rd_addr = 5'd19;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (20) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.Write_Enable, bus.Write_Data, bus.Write_Adress} !== '0) begin
      errors++;
      $display("FAIL abort_outputs got busy=%b we=%b wd=%h wa=%h exp all 0", bus.busy, bus.Write_Enable, bus.Write_Data, bus.Write_Adress);
    end
    @(negedge clock);
    reset = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (bus.Write_Enable === 1'b1 || bus.busy === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL abort_no_write got %0d active cycles exp 0", pulses);
    end
    run_op("mulhu_after_reset", 3'd3, 32'h8000_0000, 32'd6, 5'd20, 32'd3, 0);
  endtask
  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      logic [2:0] op;
      logic [31:0] a, b;
      logic [4:0] rd;
      op = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      rd = 5'($urandom_range(1, 31));
      run_op("random", op, a, b, rd, model(op, a, b), 0);
    end
  endtask
  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_special();
    test_restart();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
